adc_trig_capture: RTL and testbench

Edge-triggered capture buffer between the 8-bit ADC input and the LCD waveform renderer. Samples `ad_data` every `ad_clk` cycle into a circular on-chip RAM, detects a level crossing, and freezes a window of `DEPTH` samples with `PRE_DEPTH` samples before the trigger. It then presents the frozen window through a random-access read port indexed oldest-first, which the renderer scans.

---
 rtl/adc_trig_capture.sv | 171 +++++++++++++++++
 tb/tb_adc_trig_capture.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/adc_trig_capture.sv
// rtl/adc_trig_capture.sv - edge-triggered ADC capture window with oldest-first read port; optional TRIG_TIMEOUT_EN auto-trigger
module adc_trig_capture #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int PRE_DEPTH   = 256,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              ad_clk,
    input  logic              sys_rst,
    input  logic [7:0]        ad_data,
    input  logic              arm,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              trig_forced
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    // Counter terminal values: PRE ends on its PRE_DEPTH-th write, POST on its
    // (DEPTH-PRE_DEPTH-1)-th write, so the frozen window holds exactly DEPTH samples.
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_DEPTH - 2);
    localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        s_cur;
    logic [7:0]        s_prev;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] rd_idx;
    logic              wr_en;
    logic              start;
    logic              trig_hit;
    logic              force_hit;
    logic              fire;
    logic [7:0]        mem [DEPTH];

    // Level-crossing detect on the registered sample pair; level and edge are used live.
    always_comb begin
        trig_hit = 1'b0;
        if (trig_edge)
            trig_hit = (s_prev > trig_level) && (s_cur <= trig_level);
        else
            trig_hit = (s_prev < trig_level) && (s_cur >= trig_level);
    end

    assign start  = ((state == S_IDLE) || (state == S_DONE)) && arm;
    assign fire   = (state == S_WAIT) && (trig_hit || force_hit);
    assign rd_idx = start_ptr + rd_addr;

`ifdef TRIG_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              forced_q;

    assign force_hit   = (wait_cnt == WAIT_W'(TIMEOUT_CYC));
    assign trig_forced = forced_q;

    // WAIT-cycle counter; a forced trigger is flagged only when no real crossing coincides.
    always_ff @(posedge ad_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wait_cnt <= '0;
            forced_q <= 1'b0;
        end else if (start) begin
            wait_cnt <= '0;
            forced_q <= 1'b0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (force_hit && !trig_hit)
                forced_q <= 1'b1;
        end
    end
`else
    assign force_hit   = 1'b0;
    assign trig_forced = 1'b0;
`endif

    // State register.
    always_ff @(posedge ad_clk or posedge sys_rst) begin
        if (sys_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; arm is only honoured from IDLE or DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arm) state_nxt = S_PRE;
            S_PRE:   if (pre_cnt == PRE_LAST) state_nxt = S_WAIT;
            S_WAIT:  if (fire) state_nxt = S_POST;
            S_POST:  if (post_cnt == POST_LAST) state_nxt = S_DONE;
            S_DONE:  if (arm) state_nxt = S_PRE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs and write enable decoded from the state register.
    always_comb begin
        cap_busy = 1'b0;
        cap_done = 1'b0;
        wr_en    = 1'b0;
        case (state)
            S_PRE, S_WAIT, S_POST: begin
                cap_busy = 1'b1;
                wr_en    = 1'b1;
            end
            S_DONE:  cap_done = 1'b1;
            default: ;
        endcase
    end

    // Sample pipeline, write pointer, window start and phase counters.
    always_ff @(posedge ad_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s_cur     <= '0;
            s_prev    <= '0;
            wr_ptr    <= '0;
            start_ptr <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
        end else begin
            s_cur  <= ad_data;
            s_prev <= s_cur;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (start) begin
                pre_cnt  <= '0;
                post_cnt <= '0;
            end else begin
                if (state == S_PRE)
                    pre_cnt <= pre_cnt + 1'b1;
                if (state == S_POST)
                    post_cnt <= post_cnt + 1'b1;
            end
            // The sample written on the trigger edge sits PRE_DEPTH slots after the window start.
            if (fire)
                start_ptr <= wr_ptr - PRE_OFF;
        end
    end

    // Circular sample RAM; contents survive reset.
    always_ff @(posedge ad_clk) begin
        if (wr_en)
            mem[wr_ptr] <= s_cur;
    end

    // Registered read, logical index rebased onto the window start.
    always_ff @(posedge ad_clk or posedge sys_rst) begin
        if (sys_rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_idx];
    end

endmodule

// File: tb/tb_adc_trig_capture.sv
// tb/tb_adc_trig_capture.sv - directed self-checking bench for adc_trig_capture
`timescale 1ns/1ps
module tb_adc_trig_capture;

    logic       ad_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] ad_data = 8'h00;
    logic       arm = 1'b0;
    logic [7:0] trig_level = 8'h80;
    logic       trig_edge = 1'b0;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       cap_busy;
    logic       cap_done;
    logic       trig_forced;

    int total = 0;
    int bad = 0;
    int mode = 0;
    int n = 0;
    int edges;

    adc_trig_capture #(
        .DEPTH(1024), .ADDR_W(10), .PRE_DEPTH(256), .TIMEOUT_CYC(100)
    ) dut (
        .ad_clk(ad_clk), .sys_rst(sys_rst), .ad_data(ad_data), .arm(arm),
        .trig_level(trig_level), .trig_edge(trig_edge), .rd_addr(rd_addr),
        .rd_data(rd_data), .cap_busy(cap_busy), .cap_done(cap_done),
        .trig_forced(trig_forced)
    );

    always #5 ad_clk = ~ad_clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Sample presented before edge k of a capture (edge 0 = arm edge).
    function automatic logic [7:0] gen(input int k);
        case (mode)
            0: gen = 8'(k % 256);
            1: gen = 8'(255 - (k % 256));
            2: gen = 8'h40;
            default: begin
                if (k < 300)       gen = 8'h80;
                else if (k < 310)  gen = 8'h81;
                else if (k == 310) gen = 8'h7F;
                else if (k == 311) gen = 8'h80;
                else               gen = 8'h90;
            end
        endcase
    endfunction

    task automatic tick();
        ad_data = gen(n);
        @(posedge ad_clk);
        #1;
        n++;
    endtask

    // Arm, optionally pulse arm again at edge arm_at, run until cap_done or stop_at.
    task automatic capture(input int arm_at, input int stop_at, output int done_edge);
        done_edge = -1;
        n = 0;
        arm = 1'b1;
        tick();
        chk("arm_busy", int'(cap_busy), 1);
        chk("arm_done", int'(cap_done), 0);
        chk("arm_forced_clr", int'(trig_forced), 0);
        for (int e = 1; e <= stop_at; e++) begin
            arm = (e == arm_at);
            tick();
            if (cap_done) begin
                done_edge = e;
                break;
            end
        end
        arm = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int addr, input int exp);
        rd_addr = 10'(addr);
        tick();
        chk(tag, int'(rd_data), exp);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_busy", int'(cap_busy), 0);
        chk("rst_done", int'(cap_done), 0);
        chk("rst_forced", int'(trig_forced), 0);
        sys_rst = 1'b0;
        repeat (2) tick();

        // Rising ramp, arm pulsed mid-POST must be ignored
        mode = 0; trig_level = 8'h80; trig_edge = 1'b0;
        capture(600, 2000, edges);
        chk("rise_done_edge", edges, 1152);
        chk("rise_busy_off", int'(cap_busy), 0);
        rd_chk("rise_rd256", 256, 8'd128);
        rd_chk("rise_rd255", 255, 8'd127);
        rd_chk("rise_rd0", 0, 8'd128);
        rd_chk("rise_rd1023", 1023, 8'd127);
        rd_chk("rise_rd1024wrap", 1024, 8'd128);

        // Re-arm from DONE
        capture(-1, 2000, edges);
        chk("rearm_done_edge", edges, 1152);
        rd_chk("rearm_rd256", 256, 8'd128);
        rd_chk("rearm_rd512", 512, 8'd128);

        // Falling ramp
        mode = 1; trig_level = 8'h40; trig_edge = 1'b1;
        capture(-1, 2000, edges);
        chk("fall_done_edge", edges, 1215);
        rd_chk("fall_rd256", 256, 8'h40);
        rd_chk("fall_rd255", 255, 8'h41);

        // Threshold boundary: 0x80->0x81 must not fire, 0x7F->0x80 must
        mode = 3; trig_level = 8'h80; trig_edge = 1'b0;
        capture(-1, 2000, edges);
        chk("bnd_done_edge", edges, 1079);
        rd_chk("bnd_rd256", 256, 8'h80);
        rd_chk("bnd_rd255", 255, 8'h7F);
        rd_chk("bnd_rd254", 254, 8'h81);

        // Timeout on a flat signal that never crosses
        mode = 2; trig_level = 8'h80; trig_edge = 1'b0;
`ifdef TRIG_TIMEOUT_EN
        capture(-1, 2000, edges);
        chk("to_done_edge", edges, 1124);
        chk("to_forced", int'(trig_forced), 1);
        rd_chk("to_rd256", 256, 8'h40);
`else
        capture(-1, 3000, edges);
        chk("to_no_done", edges, -1);
        chk("to_busy_held", int'(cap_busy), 1);
        chk("to_forced_zero", int'(trig_forced), 0);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
`endif

        // Asynchronous reset in the middle of POST
        mode = 0; trig_level = 8'h80; trig_edge = 1'b0;
        capture(-1, 700, edges);
        chk("prerst_busy", int'(cap_busy), 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_busy", int'(cap_busy), 0);
        chk("arst_done", int'(cap_done), 0);
        chk("arst_rd_data", int'(rd_data), 0);
        chk("arst_forced", int'(trig_forced), 0);
        tick();
        chk("arst_idle_busy", int'(cap_busy), 0);
        sys_rst = 1'b0;
        tick();
        capture(-1, 2000, edges);
        chk("post_rst_done_edge", edges, 1152);
        rd_chk("post_rst_rd256", 256, 8'd128);
        rd_chk("post_rst_rd255", 255, 8'd127);
        rd_chk("post_rst_rd0", 0, 8'd128);
        rd_chk("post_rst_rd1023", 1023, 8'd127);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
